// File: rtl/alu_op_pkg.sv
// ALU operation codes shared by the control unit and the datapath ALU.
package alu_op_pkg;
    localparam int ALU_OP_BITS = 5;

    localparam logic [ALU_OP_BITS-1:0] ALU_NOP  = 5'd0;
    localparam logic [ALU_OP_BITS-1:0] ALU_ADD  = 5'd1;
    localparam logic [ALU_OP_BITS-1:0] ALU_ADDU = 5'd2;
    localparam logic [ALU_OP_BITS-1:0] ALU_SUB  = 5'd3;
    localparam logic [ALU_OP_BITS-1:0] ALU_SUBU = 5'd4;
    localparam logic [ALU_OP_BITS-1:0] ALU_AND  = 5'd5;
    localparam logic [ALU_OP_BITS-1:0] ALU_OR   = 5'd6;
    localparam logic [ALU_OP_BITS-1:0] ALU_XOR  = 5'd7;
    localparam logic [ALU_OP_BITS-1:0] ALU_NOR  = 5'd8;
    localparam logic [ALU_OP_BITS-1:0] ALU_SLT  = 5'd9;
    localparam logic [ALU_OP_BITS-1:0] ALU_SLL  = 5'd10;
    localparam logic [ALU_OP_BITS-1:0] ALU_SRL  = 5'd11;
    localparam logic [ALU_OP_BITS-1:0] ALU_SRA  = 5'd12;
    localparam logic [ALU_OP_BITS-1:0] ALU_SLLV = 5'd13;
    localparam logic [ALU_OP_BITS-1:0] ALU_SRLV = 5'd14;
    localparam logic [ALU_OP_BITS-1:0] ALU_MULT = 5'd15;
    localparam logic [ALU_OP_BITS-1:0] ALU_DIV  = 5'd16;
    localparam logic [ALU_OP_BITS-1:0] ALU_BEQ  = 5'd17;
    localparam logic [ALU_OP_BITS-1:0] ALU_BNE  = 5'd18;
    localparam logic [ALU_OP_BITS-1:0] ALU_BLEZ = 5'd19;
    localparam logic [ALU_OP_BITS-1:0] ALU_BGTZ = 5'd20;
endpackage

// File: rtl/cu_pkg.sv
// Types and MIPS opcode/funct encodings for the multi-cycle control unit.
package cu_pkg;
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MULDIV = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        CL_RALU, CL_MULDIV, CL_JR, CL_J, CL_JAL,
        CL_BRANCH, CL_IALU, CL_LW, CL_SW, CL_ILLEGAL
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLEZ  = 6'd6;
    localparam logic [5:0] OP_BGTZ  = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL     = 6'd0;
    localparam logic [5:0] FN_SRL     = 6'd2;
    localparam logic [5:0] FN_SRA     = 6'd3;
    localparam logic [5:0] FN_SLLV    = 6'd4;
    localparam logic [5:0] FN_SRLV    = 6'd6;
    localparam logic [5:0] FN_JR      = 6'd8;
    localparam logic [5:0] FN_SYSCALL = 6'd12;
    localparam logic [5:0] FN_MULT    = 6'd24;
    localparam logic [5:0] FN_DIV     = 6'd26;
    localparam logic [5:0] FN_ADD     = 6'd32;
    localparam logic [5:0] FN_ADDU    = 6'd33;
    localparam logic [5:0] FN_SUB     = 6'd34;
    localparam logic [5:0] FN_SUBU    = 6'd35;
    localparam logic [5:0] FN_AND     = 6'd36;
    localparam logic [5:0] FN_OR      = 6'd37;
    localparam logic [5:0] FN_XOR     = 6'd38;
    localparam logic [5:0] FN_NOR     = 6'd39;
    localparam logic [5:0] FN_SLT     = 6'd42;
endpackage

// File: rtl/cu_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class and ALU op.
module cu_decode
    import cu_pkg::*;
    import alu_op_pkg::*;
#(
    parameter int ALUOP_W = 5
) (
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output iclass_e            iclass,
    output logic [ALUOP_W-1:0] alu_op
);
    always_comb begin
        iclass = CL_ILLEGAL;
        alu_op = ALUOP_W'(ALU_NOP);
        case (opcode)
            OP_RTYPE: begin
                iclass = CL_RALU;
                case (funct)
                    FN_SLL:  alu_op = ALUOP_W'(ALU_SLL);
                    FN_SRL:  alu_op = ALUOP_W'(ALU_SRL);
                    FN_SRA:  alu_op = ALUOP_W'(ALU_SRA);
                    FN_SLLV: alu_op = ALUOP_W'(ALU_SLLV);
                    FN_SRLV: alu_op = ALUOP_W'(ALU_SRLV);
                    FN_JR:   iclass = CL_JR;
                    FN_MULT: begin iclass = CL_MULDIV; alu_op = ALUOP_W'(ALU_MULT); end
                    FN_DIV:  begin iclass = CL_MULDIV; alu_op = ALUOP_W'(ALU_DIV);  end
                    FN_ADD:  alu_op = ALUOP_W'(ALU_ADD);
                    FN_ADDU: alu_op = ALUOP_W'(ALU_ADDU);
                    FN_SUB:  alu_op = ALUOP_W'(ALU_SUB);
                    FN_SUBU: alu_op = ALUOP_W'(ALU_SUBU);
                    FN_AND:  alu_op = ALUOP_W'(ALU_AND);
                    FN_OR:   alu_op = ALUOP_W'(ALU_OR);
                    FN_XOR:  alu_op = ALUOP_W'(ALU_XOR);
                    FN_NOR:  alu_op = ALUOP_W'(ALU_NOR);
                    FN_SLT:  alu_op = ALUOP_W'(ALU_SLT);
                    // SYSCALL and unknown functs both stop the machine
                    default: iclass = CL_ILLEGAL;
                endcase
            end
            OP_J:     iclass = CL_J;
            OP_JAL:   iclass = CL_JAL;
            OP_BEQ:   begin iclass = CL_BRANCH; alu_op = ALUOP_W'(ALU_BEQ);  end
            OP_BNE:   begin iclass = CL_BRANCH; alu_op = ALUOP_W'(ALU_BNE);  end
            OP_BLEZ:  begin iclass = CL_BRANCH; alu_op = ALUOP_W'(ALU_BLEZ); end
            OP_BGTZ:  begin iclass = CL_BRANCH; alu_op = ALUOP_W'(ALU_BGTZ); end
            OP_ADDI:  begin iclass = CL_IALU;   alu_op = ALUOP_W'(ALU_ADD);  end
            OP_ADDIU: begin iclass = CL_IALU;   alu_op = ALUOP_W'(ALU_ADDU); end
            OP_ANDI:  begin iclass = CL_IALU;   alu_op = ALUOP_W'(ALU_AND);  end
            OP_ORI:   begin iclass = CL_IALU;   alu_op = ALUOP_W'(ALU_OR);   end
            OP_XORI:  begin iclass = CL_IALU;   alu_op = ALUOP_W'(ALU_XOR);  end
            OP_LW:    begin iclass = CL_LW;     alu_op = ALUOP_W'(ALU_ADD);  end
            OP_SW:    begin iclass = CL_SW;     alu_op = ALUOP_W'(ALU_ADD);  end
            default:  iclass = CL_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control FSM: fetch, decode, execute, mul/div wait, memory, write-back, halt.
module multicycle_cu
    import cu_pkg::*;
#(
    parameter int ALUOP_W   = 5,
    parameter int MD_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [31:0]        inst,
    input  logic               inst_ready,
    input  logic               mem_ready,
    output logic               inst_req,
    output logic               ir_write,
    output logic               pc_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_src,
    output logic               reg_dest,
    output logic               mem_to_reg,
    output logic               link,
    output logic               reg_write,
    output logic               branch,
    output logic               jump,
    output logic               jump_reg,
    output logic               halted,
    output logic [2:0]         state
);
    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

    state_e             state_q, state_d;
    iclass_e            class_q, class_d;
    logic [5:0]         opcode_q, opcode_d;
    logic [5:0]         funct_q, funct_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic [7:0]         cnt_q, cnt_d;

    iclass_e            dec_class;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic               inst_fields_unused;

    // Only opcode and funct drive control; the operand fields belong to the datapath.
    assign inst_fields_unused = ^inst[25:6];

    cu_decode #(.ALUOP_W(ALUOP_W)) u_decode (
        .opcode (opcode_q),
        .funct  (funct_q),
        .iclass (dec_class),
        .alu_op (dec_alu_op)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q  <= ST_FETCH;
            class_q  <= CL_ILLEGAL;
            opcode_q <= '0;
            funct_q  <= '0;
            aluop_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            class_q  <= class_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
            aluop_q  <= aluop_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        opcode_d   = opcode_q;
        funct_d    = funct_q;
        aluop_d    = aluop_q;
        cnt_d      = cnt_q;
        inst_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_op     = '0;
        alu_src    = 1'b0;
        reg_dest   = 1'b0;
        mem_to_reg = 1'b0;
        link       = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jump_reg   = 1'b0;
        halted     = 1'b0;
        state      = state_q;

        case (state_q)
            ST_FETCH: begin
                // Fetch stays quiet while reset is held so every output reads 0 in reset.
                inst_req = rst_b;
                if (rst_b && inst_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    opcode_d = inst[31:26];
                    funct_d  = inst[5:0];
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                aluop_d = dec_alu_op;
                state_d = (dec_class == CL_ILLEGAL) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                alu_op  = aluop_q;
                alu_src = class_q inside {CL_IALU, CL_LW, CL_SW};
                case (class_q)
                    CL_RALU, CL_IALU: state_d = ST_WB;
                    CL_MULDIV: begin
                        cnt_d   = MD_LOAD;
                        state_d = (MD_CYCLES == 1) ? ST_WB : ST_MULDIV;
                    end
                    CL_BRANCH: begin branch = 1'b1; state_d = ST_FETCH; end
                    CL_J:      begin jump = 1'b1; state_d = ST_FETCH; end
                    CL_JR:     begin jump = 1'b1; jump_reg = 1'b1; state_d = ST_FETCH; end
                    CL_JAL:    begin jump = 1'b1; state_d = ST_WB; end
                    CL_LW, CL_SW: state_d = ST_MEM;
                    default:   state_d = ST_HALT;
                endcase
            end
            ST_MULDIV: begin
                alu_op = aluop_q;
                // EXEC counts as the first busy cycle, so leave when the count would reach 0.
                if (cnt_q <= 8'd1) begin
                    cnt_d   = '0;
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_MEM: begin
                mem_read  = (class_q == CL_LW);
                mem_write = (class_q == CL_SW);
                if (mem_ready) begin
                    state_d = (class_q == CL_LW) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dest   = class_q inside {CL_RALU, CL_MULDIV};
                mem_to_reg = (class_q == CL_LW);
                link       = (class_q == CL_JAL);
                state_d    = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_cu.sv
// Randomised bench: each instruction is expanded into its expected per-cycle output trace and compared.
module tb_multicycle_cu;
    import cu_pkg::*;
    import alu_op_pkg::*;

    localparam int MD = 4;
    localparam int K_RALU = 0, K_MD = 1, K_JR = 2, K_J = 3, K_JAL = 4;
    localparam int K_BR = 5, K_IALU = 6, K_LW = 7, K_SW = 8, K_BAD = 9;
    localparam logic [11:0] LEGAL [0:29] = '{
        {6'd0, 6'd0}, {6'd0, 6'd2}, {6'd0, 6'd3}, {6'd0, 6'd4}, {6'd0, 6'd6},
        {6'd0, 6'd8}, {6'd0, 6'd24}, {6'd0, 6'd26}, {6'd0, 6'd32}, {6'd0, 6'd33},
        {6'd0, 6'd34}, {6'd0, 6'd35}, {6'd0, 6'd36}, {6'd0, 6'd37}, {6'd0, 6'd38},
        {6'd0, 6'd39}, {6'd0, 6'd42}, {6'd2, 6'd0}, {6'd3, 6'd0}, {6'd4, 6'd0},
        {6'd5, 6'd0}, {6'd6, 6'd0}, {6'd7, 6'd0}, {6'd8, 6'd0}, {6'd9, 6'd0},
        {6'd12, 6'd0}, {6'd13, 6'd0}, {6'd14, 6'd0}, {6'd35, 6'd0}, {6'd43, 6'd0}
    };

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] inst = '0;
    logic        inst_ready = 1'b0;
    logic        mem_ready = 1'b0;
    logic        inst_req, ir_write, pc_write, mem_read, mem_write;
    logic [4:0]  alu_op;
    logic        alu_src, reg_dest, mem_to_reg, link, reg_write;
    logic        branch, jump, jump_reg, halted;
    logic [2:0]  state;

    always #5 clk = ~clk;

    multicycle_cu #(.ALUOP_W(5), .MD_CYCLES(MD)) dut (
        .clk(clk), .rst_b(rst_b), .inst(inst), .inst_ready(inst_ready), .mem_ready(mem_ready),
        .inst_req(inst_req), .ir_write(ir_write), .pc_write(pc_write),
        .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op), .alu_src(alu_src),
        .reg_dest(reg_dest), .mem_to_reg(mem_to_reg), .link(link), .reg_write(reg_write),
        .branch(branch), .jump(jump), .jump_reg(jump_reg), .halted(halted), .state(state)
    );

    typedef struct packed {
        logic inst_req; logic ir_write; logic pc_write; logic mem_read; logic mem_write;
        logic [4:0] alu_op;
        logic alu_src; logic reg_dest; logic mem_to_reg; logic link; logic reg_write;
        logic branch; logic jump; logic jump_reg; logic halted;
        logic [2:0] state;
    } outs_t;

    // ir/mr: 0 = drive low, 1 = drive high, 2 = random (input is ignored in that cycle)
    typedef struct { outs_t o; int ir; int mr; bit mem; } cyc_t;

    cyc_t  trace[$];
    outs_t act;
    int    n_checks = 0;
    int    n_errors = 0;
    int    txn = 0;

    assign act = {inst_req, ir_write, pc_write, mem_read, mem_write, alu_op, alu_src, reg_dest,
                  mem_to_reg, link, reg_write, branch, jump, jump_reg, halted, state};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn, output logic [4:0] alu);
        int k;
        k = K_BAD;
        alu = ALU_NOP;
        if (op == 6'd0) begin
            k = K_RALU;
            case (fn)
                6'd0:  alu = ALU_SLL;
                6'd2:  alu = ALU_SRL;
                6'd3:  alu = ALU_SRA;
                6'd4:  alu = ALU_SLLV;
                6'd6:  alu = ALU_SRLV;
                6'd8:  k = K_JR;
                6'd24: begin k = K_MD; alu = ALU_MULT; end
                6'd26: begin k = K_MD; alu = ALU_DIV; end
                6'd32: alu = ALU_ADD;
                6'd33: alu = ALU_ADDU;
                6'd34: alu = ALU_SUB;
                6'd35: alu = ALU_SUBU;
                6'd36: alu = ALU_AND;
                6'd37: alu = ALU_OR;
                6'd38: alu = ALU_XOR;
                6'd39: alu = ALU_NOR;
                6'd42: alu = ALU_SLT;
                default: k = K_BAD;
            endcase
        end else begin
            case (op)
                6'd2:  k = K_J;
                6'd3:  k = K_JAL;
                6'd4:  begin k = K_BR; alu = ALU_BEQ; end
                6'd5:  begin k = K_BR; alu = ALU_BNE; end
                6'd6:  begin k = K_BR; alu = ALU_BLEZ; end
                6'd7:  begin k = K_BR; alu = ALU_BGTZ; end
                6'd8:  begin k = K_IALU; alu = ALU_ADD; end
                6'd9:  begin k = K_IALU; alu = ALU_ADDU; end
                6'd12: begin k = K_IALU; alu = ALU_AND; end
                6'd13: begin k = K_IALU; alu = ALU_OR; end
                6'd14: begin k = K_IALU; alu = ALU_XOR; end
                6'd35: begin k = K_LW; alu = ALU_ADD; end
                6'd43: begin k = K_SW; alu = ALU_ADD; end
                default: k = K_BAD;
            endcase
        end
        return k;
    endfunction

    function automatic void push(input outs_t o, input int ir, input int mr, input bit m);
        cyc_t c;
        c.o = o; c.ir = ir; c.mr = mr; c.mem = m;
        trace.push_back(c);
    endfunction

    task automatic reset_pulse();
        rst_b = 1'b0;
        mem_ready = 1'b0;
        inst_ready = 1'($urandom);
        @(posedge clk); #1;
        rst_b = 1'b1;
    endtask

    // Expected behaviour of one instruction: fetch wait fw, memory wait mw, halt observed for halt_n cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                             input int halt_n, input bit abort_mem);
        logic [4:0]  alu;
        logic [31:0] word;
        outs_t       o;
        int          k;
        k = kind_of(op, fn, alu);
        word = (op == 6'd0) ? {op, 20'($urandom), fn} : {op, 26'($urandom)};
        trace.delete();
        o = '0; o.state = ST_FETCH; o.inst_req = 1'b1;
        repeat (fw) push(o, 0, 2, 1'b0);
        o.ir_write = 1'b1; o.pc_write = 1'b1;
        push(o, 1, 2, 1'b0);
        o = '0; o.state = ST_DECODE;
        push(o, 2, 2, 1'b0);
        if (k == K_BAD) begin
            o = '0; o.state = ST_HALT; o.halted = 1'b1;
            repeat (halt_n) push(o, 2, 2, 1'b0);
        end else begin
            o = '0; o.state = ST_EXEC; o.alu_op = alu;
            o.alu_src  = (k == K_IALU || k == K_LW || k == K_SW);
            o.branch   = (k == K_BR);
            o.jump     = (k == K_J || k == K_JR || k == K_JAL);
            o.jump_reg = (k == K_JR);
            push(o, 2, 2, 1'b0);
            if (k == K_MD) begin
                o = '0; o.state = ST_MULDIV; o.alu_op = alu;
                repeat (MD - 1) push(o, 2, 2, 1'b0);
            end
            if (k == K_LW || k == K_SW) begin
                o = '0; o.state = ST_MEM; o.mem_read = (k == K_LW); o.mem_write = (k == K_SW);
                for (int w = 0; w <= mw; w++) push(o, 2, (w == mw) ? 1 : 0, 1'b1);
            end
            if (k == K_RALU || k == K_MD || k == K_IALU || k == K_LW || k == K_JAL) begin
                o = '0; o.state = ST_WB; o.reg_write = 1'b1;
                o.reg_dest = (k == K_RALU || k == K_MD);
                o.mem_to_reg = (k == K_LW);
                o.link = (k == K_JAL);
                push(o, 2, 2, 1'b0);
            end
        end
        txn++;
        $display("txn %0d: op=%0d fn=%0d fetch_wait=%0d mem_wait=%0d expected_cycles=%0d%s",
                 txn, op, fn, fw, mw, trace.size(), abort_mem ? " (reset in MEM)" : "");
        foreach (trace[i]) begin
            inst_ready = (trace[i].ir == 2) ? 1'($urandom) : 1'(trace[i].ir);
            inst       = (trace[i].ir == 1) ? word : $urandom;
            mem_ready  = (trace[i].mr == 2) ? 1'($urandom) : 1'(trace[i].mr);
            @(negedge clk);
            check($sformatf("txn%0d_cyc%0d", txn, i), 32'(act), 32'(trace[i].o));
            @(posedge clk); #1;
            if (abort_mem && trace[i].mem) break;
        end
        if (abort_mem || k == K_BAD) reset_pulse();
    endtask

    initial begin
        outs_t z;
        logic [11:0] pick;
        logic [5:0]  op, fn;
        rst_b = 1'b0;
        inst_ready = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        z = '0; z.state = ST_FETCH;
        check("reset_outputs", 32'(act), 32'(z));
        @(posedge clk); #1;
        rst_b = 1'b1;
        inst_ready = 1'b0;
        mem_ready = 1'b0;

        run_instr(6'd0, 6'd32, 0, 0, 0, 1'b0);   // ADD
        run_instr(6'd35, 6'd0, 0, 3, 0, 1'b0);   // LW, slow memory
        run_instr(6'd0, 6'd24, 0, 0, 0, 1'b0);   // MULT
        run_instr(6'd3, 6'd0, 0, 0, 0, 1'b0);    // JAL
        run_instr(6'd4, 6'd0, 0, 0, 0, 1'b0);    // BEQ
        run_instr(6'd43, 6'd0, 2, 1, 0, 1'b0);   // SW
        run_instr(6'd0, 6'd8, 1, 0, 0, 1'b0);    // JR
        run_instr(6'd63, 6'd0, 0, 0, 20, 1'b0);  // illegal opcode, then reset
        run_instr(6'd0, 6'd12, 0, 0, 3, 1'b0);   // SYSCALL
        run_instr(6'd43, 6'd0, 0, 5, 0, 1'b1);   // SW aborted by reset in MEM
        run_instr(6'd0, 6'd33, 0, 0, 0, 1'b0);   // ADDU right after the abort

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                pick = LEGAL[$urandom_range(0, 29)];
                op = pick[11:6];
                fn = pick[5:0];
            end
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 4), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
